serial_pad_scanner: RTL
=======================

Name: serial_pad_scanner

Overview:
- Parametrised successor to the single-pad input controller.
- Scans NUM_PADS NES-style serial shift-register gamepads in parallel. All pads share one latch line and one pulse line; each pad has its own data line.
- Each poll produces registered held-button vectors, one-cycle press events and a priority-encoded button code per pad for the game logic.
- Sits between the board pins and the Tetris control FSM.

Parameters:
- CLK_DIV, 4, clk cycles per slow tick (>=2); 50 MHz with 300 gives 6 us ticks.
- NUM_BUTTONS, 8, bits shifted per pad per frame (2..15).
- NUM_PADS, 2, number of pads / data lines (1..4).
- POLL_TICKS, 10, idle ticks between frames (>=1).
- REPEAT_DELAY, 8, frames a button is held before the first auto-repeat (only with AUTO_REPEAT_EN).
- REPEAT_RATE, 3, frames between subsequent repeats (only with AUTO_REPEAT_EN).
- REPEAT_MASK, 8'hF0, buttons that auto-repeat (only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new frame starts; an in-progress frame completes.
- pad_data  in  NUM_PADS  serial data, active-low (0 = pressed), bit p = pad p.
- pad_latch  out  1  shared latch strobe.
- pad_pulse  out  1  shared shift clock.
- buttons  out  NUM_PADS*NUM_BUTTONS  held state, active-high; pad p occupies [p*NUM_BUTTONS +: NUM_BUTTONS]; bit 0 = first bit shifted (A).
- pressed  out  NUM_PADS*NUM_BUTTONS  one-cycle event per button, same layout as buttons.
- button_code  out  NUM_PADS*CODE_W  per-pad code: 0 = none pressed, k+1 = lowest-index pressed button k.
- frame_valid  out  1  one-cycle pulse when the outputs update.
- tick  out  1  one-cycle slow-tick strobe, for debug.

Behaviour:
- Tick generation: tick_cnt runs free from 0 to CLK_DIV-1. tick is high in the cycle tick_cnt == CLK_DIV-1. All FSM transitions occur only on tick.
- FSM states: IDLE, LATCH, GAP, PULSE_HI, PULSE_LO.
  - IDLE: counts POLL_TICKS ticks. On expiry, goes to LATCH if enable=1; otherwise stays in IDLE with the count saturated.
  - LATCH: pad_latch=1 for 2 ticks, then GAP.
  - GAP: 1 tick. pad_data is sampled into bit 0 on the tick that leaves GAP.
  - PULSE_HI: pad_pulse=1 for 1 tick, then PULSE_LO.
  - PULSE_LO: 1 tick. Bit k is sampled on the tick that leaves PULSE_LO. Returns to PULSE_HI while k < NUM_BUTTONS-1, otherwise goes to IDLE.
- Frame period: 3 + 2*(NUM_BUTTONS-1) + POLL_TICKS ticks.
- Sampled bits are inverted into a shadow register. buttons, pressed, button_code and frame_valid update one cycle after the final sample.
- pressed = new & ~old; it and frame_valid are high for exactly that one cycle.
- pad_latch and pad_pulse are registered, glitch-free, and never high together.
- Reset (any time, including mid-frame): all outputs and counters go to 0, FSM to IDLE, shadow cleared. After release, the first frame starts after POLL_TICKS ticks. No pressed event is generated for buttons already held at the first frame after reset unless their old state was 0; old is 0 after reset, so held buttons do report pressed once.
- A deasserted enable has no effect on outputs; held state is retained.
- CODE_W = $clog2(NUM_BUTTONS+1).

Optional Feature:
- SERIAL_PAD_AUTO_REPEAT_EN defined:
  - Each REPEAT_MASK button of each pad has a frame counter, cleared on release.
  - While held, pressed re-pulses on the frame where the counter equals REPEAT_DELAY, and every REPEAT_RATE frames after that.
  - Counters saturate-wrap within REPEAT_DELAY+REPEAT_RATE.
- Not defined: pressed fires only on a 0->1 transition; no counters are synthesised.

Decomposition:
- Shared package, pad_pkg:
  - FSM state enum.
  - Button index constants: BTN_A=0, B=1, SELECT=2, START=3, UP=4, DOWN=5, LEFT=6, RIGHT=7.
  - Latch length constant (2 ticks).
- One sub-module, pad_channel, instantiated NUM_PADS times: shadow shift register, held/edge registers, priority encoder and repeat counters. The top level holds the tick counter and FSM.

Test Plan:
- Defaults, all pad_data=1 -> pad_latch high 8 cycles every 108 cycles; 7 pad_pulse high phases of 4 cycles; buttons=0, button_code=0, frame_valid every 108 cycles.
- Pad0 drives bit 2 low (SELECT), pad1 idle -> buttons=16'h0004, pressed=16'h0004 for 1 cycle, button_code pad0=3, pad1=0. Next frame with the same input: pressed=0.
- Pad1 drives bits 0 and 5 low -> buttons[15:8]=8'h21, button_code pad1=1 (A wins priority).
- reset asserted during the 4th PULSE_HI -> pad_latch=pad_pulse=0 within the same cycle, outputs 0. After release, the first pad_latch appears after 10 ticks (40 cycles).
- enable=0 during a frame -> the frame completes and frame_valid fires; no further pad_latch until enable=1, after which pad_latch asserts at the next tick.
- Macro defined, UP held 20 frames -> pressed[4] at frames 1, 9, 12, 15, 18; none while released.

Source files
------------

// File: rtl/pad_pkg.sv
// pad_pkg: shared FSM states, button indices and latch length for the serial pad scanner.
package pad_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, GAP, PULSE_HI, PULSE_LO} state_t;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
  localparam int LATCH_TICKS = 2;
endpackage

// File: rtl/pad_channel.sv
// pad_channel: per-pad shadow register, held/edge outputs and priority code.
// Repeat counters exist only when SERIAL_PAD_AUTO_REPEAT_EN is defined.
module pad_channel #(
  parameter int NUM_BUTTONS = 8,
`ifdef SERIAL_PAD_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE = 3,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = 8'hF0,
`endif
  parameter int CODE_W = 4,
  parameter int BW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample,
  input  logic                   done,
  input  logic [BW-1:0]          idx,
  input  logic                   data,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [CODE_W-1:0]      code
);
  logic [NUM_BUTTONS-1:0] shadow, rep;
  logic [CODE_W-1:0] code_n;
  always_comb begin
    code_n = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) code_n = shadow[k] ? CODE_W'(k + 1) : code_n;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow <= '0;
      buttons <= '0;
      pressed <= '0;
      code <= '0;
    end else begin
      if (sample) shadow[idx] <= ~data;
      pressed <= done ? (shadow & ~buttons) | rep : '0;
      if (done) begin
        buttons <= shadow;
        code <= code_n;
      end
    end
`ifdef SERIAL_PAD_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_rep
    if (REPEAT_MASK[k]) begin : g_on
      logic [RW-1:0] cnt;
      // cnt holds frames already held before the current one
      always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (done) cnt <= !shadow[k] ? '0 : cnt == RW'(REPEAT_DELAY + REPEAT_RATE) ? RW'(REPEAT_DELAY + 1) : cnt + 1'b1;
      assign rep[k] = shadow[k] && (cnt == RW'(REPEAT_DELAY) || cnt == RW'(REPEAT_DELAY + REPEAT_RATE));
    end else begin : g_off
      assign rep[k] = 1'b0;
    end
  end
`else
  assign rep = '0;
`endif
endmodule

// File: rtl/serial_pad_scanner.sv
// serial_pad_scanner: tick divider and latch/pulse FSM polling NUM_PADS serial gamepads in parallel.
// Define SERIAL_PAD_AUTO_REPEAT_EN to add auto-repeat pulses on pressed.
module serial_pad_scanner
  import pad_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_BUTTONS = 8,
  parameter int NUM_PADS = 2,
  parameter int POLL_TICKS = 10,
`ifdef SERIAL_PAD_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE = 3,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK = 8'hF0,
`endif
  localparam int CODE_W = $clog2(NUM_BUTTONS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_PADS-1:0]             pad_data,
  output logic                            pad_latch,
  output logic                            pad_pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed,
  output logic [NUM_PADS*CODE_W-1:0]      button_code,
  output logic                            frame_valid,
  output logic                            tick
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(POLL_TICKS + 1);
  localparam int LW = $clog2(LATCH_TICKS);
  localparam int BW = $clog2(NUM_BUTTONS);
  state_t state, state_n;
  logic [DW-1:0] tick_cnt;
  logic [PW-1:0] idle_cnt;
  logic [LW-1:0] latch_cnt;
  logic [BW-1:0] bit_idx;
  logic sample, last, done;
  assign tick = tick_cnt == DW'(CLK_DIV - 1);
  assign last = sample && bit_idx == BW'(NUM_BUTTONS - 1);
  always_comb begin
    state_n = state;
    sample = 1'b0;
    if (tick)
      case (state)
        IDLE: state_n = idle_cnt == PW'(POLL_TICKS - 1) && enable ? LATCH : IDLE;
        LATCH: state_n = latch_cnt == LW'(LATCH_TICKS - 1) ? GAP : LATCH;
        GAP: begin
          state_n = PULSE_HI;
          sample = 1'b1;
        end
        PULSE_HI: state_n = PULSE_LO;
        PULSE_LO: begin
          state_n = bit_idx == BW'(NUM_BUTTONS - 1) ? IDLE : PULSE_HI;
          sample = 1'b1;
        end
        default: state_n = IDLE;
      endcase
  end
  // strobes are registered from the next state so the pins never glitch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      idle_cnt <= '0;
      latch_cnt <= '0;
      bit_idx <= '0;
      done <= 1'b0;
      frame_valid <= 1'b0;
      pad_latch <= 1'b0;
      pad_pulse <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      done <= last;
      frame_valid <= done;
      bit_idx <= last ? '0 : sample ? bit_idx + 1'b1 : bit_idx;
      if (tick) begin
        state <= state_n;
        idle_cnt <= state != IDLE ? '0 : idle_cnt == PW'(POLL_TICKS - 1) ? idle_cnt : idle_cnt + 1'b1;
        latch_cnt <= state == LATCH ? latch_cnt + 1'b1 : '0;
        pad_latch <= state_n == LATCH;
        pad_pulse <= state_n == PULSE_HI;
      end
    end
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_channel #(
`ifdef SERIAL_PAD_AUTO_REPEAT_EN
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE),
      .REPEAT_MASK(REPEAT_MASK),
`endif
      .NUM_BUTTONS(NUM_BUTTONS),
      .CODE_W(CODE_W),
      .BW(BW)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .sample(sample),
      .done(done),
      .idx(bit_idx),
      .data(pad_data[p]),
      .buttons(buttons[p*NUM_BUTTONS +: NUM_BUTTONS]),
      .pressed(pressed[p*NUM_BUTTONS +: NUM_BUTTONS]),
      .code(button_code[p*CODE_W +: CODE_W])
    );
  end
endmodule
